sip_bitplane_feeder: RTL and testbench
======================================

// Module: sip_bitplane_feeder
// PURPOSE
//  Transmit side of the sip_dot datapath. Accepts one packed multi-bit activation/weight
//  vector pair per handshake and emits a sequence of 1-bit planes (act bit a, weight bit w)
//  with sign/bin flags and shift amount. These drive the xnor dot lanes, whose adder-tree
//  result the downstream accumulator shifts by o_shift. Bit-serial precision scaling, 1..4 b.
// PARAMETERS
//  N_DOT        32  lanes per dot product (matches `N_DOT)
//  MAX_ACT_BITS  4  max activation precision per lane
//  MAX_WGT_BITS  4  max weight precision per lane
// PORTS
//  i_CLK        in   1                 clock
//  i_RST        in   1                 reset, asynchronous, active-high
//  i_valid      in   1                 upstream vector pair valid
//  o_ready      out  1                 feeder can capture a vector pair this cycle
//  i_Act_vec    in   N_DOT*MAX_ACT_BITS lane k at [MAX_ACT_BITS*k +: MAX_ACT_BITS]
//  i_Wgt_vec    in   N_DOT*MAX_WGT_BITS lane k at [MAX_WGT_BITS*k +: MAX_WGT_BITS]
//  i_act_prec   in   2                 activation precision minus 1 (0..3 -> 1..4 b)
//  i_wgt_prec   in   2                 weight precision minus 1
//  i_act_signed in   1                 activations two's complement
//  i_wgt_signed in   1                 weights two's complement
//  i_bin        in   1                 binary xnor mode: one plane, bit 0 of each operand
//  o_valid      out  1                 plane beat valid
//  i_ready      in   1                 downstream accepts beat
//  o_Act        out  N_DOT             activation bit-plane, o_Act[k] = act[k][a_idx]
//  o_Weight     out  N_DOT             weight bit-plane,     o_Weight[k] = wgt[k][w_idx]
//  o_SignI      out  1                 a_idx is act MSB and i_act_signed (negative weight)
//  o_SignW      out  1                 w_idx is wgt MSB and i_wgt_signed
//  o_bin        out  1                 captured i_bin
//  o_shift      out  3                 a_idx + w_idx
//  o_first      out  1                 first beat of vector pair (accumulator clear)
//  o_last       out  1                 last beat of vector pair (accumulator emit)
// BEHAVIOUR
//  - Reset: all outputs 0 except o_ready=0 during reset, 1 first cycle after; FSM IDLE.
//  - States: IDLE (o_valid=0), STREAM (o_valid=1). All outputs registered.
//  - o_ready = (IDLE) | (STREAM & o_last & i_ready). Capture on i_valid & o_ready:
//    latch vectors, precisions, signed flags, bin; a_idx=w_idx=0; go/stay STREAM next cycle.
//  - Beat order: w_idx outer, a_idx inner: (a0,w0),(a1,w0)..(aP,w0),(a0,w1)...; beats =
//    (act_prec+1)*(wgt_prec+1). i_bin=1 forces exactly one beat, shift 0, SignI=SignW=0.
//  - Advance only on o_valid & i_ready; otherwise every output holds stable (no bubbles,
//    no skipped planes). Last beat accepted without new capture -> IDLE.
//  - Back-to-back: capture on the last-beat cycle gives next pair's o_first beat in the
//    following cycle, zero gap.
//  - Lane bits above selected precision ignored. o_first/o_last both 1 for 1-beat pairs.
//  - i_RST mid-stream: immediate return to IDLE, captured data discarded, o_valid drops
//    asynchronously; no partial beats resume.
//  - Inputs other than i_valid are don't-care unless capturing.
// STRUCTURE
//  - Shared package/parameters.v: N_DOT, MAX_ACT_BITS, MAX_WGT_BITS, BITS_SHIFT=3,
//    state encodings IDLE/STREAM.
//  - One sub-module: bitplane_select (combinational mux, N_DOT lanes x MAX bits -> plane
//    by index); instantiated twice (act, weight). Counters and FSM stay in top.
// TESTING
//  1. act_prec=1,wgt_prec=1 unsigned, lane0 act=2'b10 wgt=2'b11, i_ready=1 -> 4 beats
//     shift 0,1,1,2; o_Act[0]=0,1,0,1; o_Weight[0]=1,1,1,1; first on beat0, last on beat3.
//  2. i_bin=1, act=4'hF wgt=4'h0 with prec=3 -> single beat, first=last=1, o_shift=0, o_bin=1.
//  3. Signed 4b act x 1b wgt: beat a_idx=3 has o_SignI=1, others 0; o_SignW=0... set
//     i_wgt_signed=1 -> o_SignW=1 every beat (w MSB is bit 0).
//  4. Backpressure: drop i_ready for 3 cycles mid-stream -> o_* frozen, beat count unchanged (4).
//  5. Back-to-back: i_valid held, two 2x2 pairs -> 8 consecutive o_valid beats, o_ready
//     high exactly on IDLE and last-beat cycles.
//  6. Assert i_RST on beat 2 of 4 -> o_valid=0 same cycle; next capture starts at shift 0, first=1.

Source files
------------

// File: rtl/sip_bitplane_feeder_pkg.sv
// ---------------------------------------------------------------------------
// sip_bitplane_feeder_pkg
//   Shared constants, FSM encoding and small helper functions for the
//   bit-plane feeder of the sip_dot datapath.
//   N_DOT        lanes per dot product
//   MAX_ACT_BITS maximum activation precision per lane
//   MAX_WGT_BITS maximum weight precision per lane
//   BITS_SHIFT   width of the plane shift amount (a_idx + w_idx, max 6)
//   PREC_W       width of precision fields and plane indices (1..4 bits)
// ---------------------------------------------------------------------------
package sip_bitplane_feeder_pkg;

  localparam int N_DOT        = 32;
  localparam int MAX_ACT_BITS = 4;
  localparam int MAX_WGT_BITS = 4;
  localparam int BITS_SHIFT   = 3;
  localparam int PREC_W       = 2;

  localparam int ACT_VEC_W    = N_DOT * MAX_ACT_BITS;
  localparam int WGT_VEC_W    = N_DOT * MAX_WGT_BITS;

  localparam logic [PREC_W-1:0] IDX_ZERO = 2'd0;
  localparam logic [PREC_W-1:0] IDX_ONE  = 2'd1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } feeder_state_e;

  // Shift applied downstream to a plane product; binary mode is never shifted.
  function automatic logic [BITS_SHIFT-1:0] beat_shift(
    input logic [PREC_W-1:0] a_idx,
    input logic [PREC_W-1:0] w_idx,
    input logic              bin
  );
    logic [BITS_SHIFT-1:0] s;
    if (bin) begin
      s = 3'd0;
    end else begin
      s = BITS_SHIFT'(a_idx) + BITS_SHIFT'(w_idx);
    end
    return s;
  endfunction

  // A plane carries negative weight when it is the MSB of a signed operand.
  function automatic logic is_sign_plane(
    input logic [PREC_W-1:0] idx,
    input logic [PREC_W-1:0] prec,
    input logic              is_signed,
    input logic              bin
  );
    return is_signed & ~bin & (idx == prec);
  endfunction

endpackage

// File: rtl/sip_bitplane_feeder_if.sv
// ---------------------------------------------------------------------------
// sip_bitplane_feeder_if
//   Groups the upstream vector-pair handshake and the downstream plane-beat
//   handshake of the feeder.
//   master : feeder side (captures vector pairs, drives plane beats)
//   slave  : environment side (drives vector pairs, accepts plane beats)
//   Upstream  : i_valid/o_ready, i_Act_vec, i_Wgt_vec, i_act_prec, i_wgt_prec,
//               i_act_signed, i_wgt_signed, i_bin
//   Downstream: o_valid/i_ready, o_Act, o_Weight, o_SignI, o_SignW, o_bin,
//               o_shift, o_first, o_last
// ---------------------------------------------------------------------------
interface sip_bitplane_feeder_if;
  import sip_bitplane_feeder_pkg::*;

  // upstream vector pair
  logic                  i_valid;
  logic                  o_ready;
  logic [ACT_VEC_W-1:0]  i_Act_vec;
  logic [WGT_VEC_W-1:0]  i_Wgt_vec;
  logic [PREC_W-1:0]     i_act_prec;
  logic [PREC_W-1:0]     i_wgt_prec;
  logic                  i_act_signed;
  logic                  i_wgt_signed;
  logic                  i_bin;

  // downstream plane beats
  logic                  o_valid;
  logic                  i_ready;
  logic [N_DOT-1:0]      o_Act;
  logic [N_DOT-1:0]      o_Weight;
  logic                  o_SignI;
  logic                  o_SignW;
  logic                  o_bin;
  logic [BITS_SHIFT-1:0] o_shift;
  logic                  o_first;
  logic                  o_last;

  modport master (
    input  i_valid, i_Act_vec, i_Wgt_vec, i_act_prec, i_wgt_prec,
           i_act_signed, i_wgt_signed, i_bin, i_ready,
    output o_ready, o_valid, o_Act, o_Weight, o_SignI, o_SignW, o_bin,
           o_shift, o_first, o_last
  );

  modport slave (
    output i_valid, i_Act_vec, i_Wgt_vec, i_act_prec, i_wgt_prec,
           i_act_signed, i_wgt_signed, i_bin, i_ready,
    input  o_ready, o_valid, o_Act, o_Weight, o_SignI, o_SignW, o_bin,
           o_shift, o_first, o_last
  );

endinterface

// File: rtl/sip_bitplane_feeder_bitplane_select.sv
// ---------------------------------------------------------------------------
// sip_bitplane_feeder_bitplane_select
//   Combinational plane extractor: from N_LANES packed lanes of LANE_BITS
//   each, returns bit idx_i of every lane as one N_LANES-wide plane.
//   vec_i   in  N_LANES*LANE_BITS  lane k at [LANE_BITS*k +: LANE_BITS]
//   idx_i   in  PREC_W             bit position to extract
//   plane_o out N_LANES            plane_o[k] = lane k bit idx_i
// ---------------------------------------------------------------------------
module sip_bitplane_feeder_bitplane_select
  import sip_bitplane_feeder_pkg::*;
#(
  parameter int N_LANES   = 32,
  parameter int LANE_BITS = 4
) (
  input  logic [N_LANES*LANE_BITS-1:0] vec_i,
  input  logic [PREC_W-1:0]            idx_i,
  output logic [N_LANES-1:0]           plane_o
);

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    logic [LANE_BITS-1:0] lane_bits;
    assign lane_bits  = vec_i[k*LANE_BITS +: LANE_BITS];
    assign plane_o[k] = lane_bits[idx_i];
  end

endmodule

// File: rtl/sip_bitplane_feeder.sv
// ---------------------------------------------------------------------------
// sip_bitplane_feeder
//   Transmit side of the sip_dot datapath. Captures one packed activation /
//   weight vector pair per upstream handshake and replays it as a sequence of
//   1-bit planes, weight index outer and activation index inner, each tagged
//   with sign flags, binary flag, shift amount and first/last markers.
//   i_CLK  in  clock
//   i_RST  in  asynchronous active-high reset
//   bus    master modport of sip_bitplane_feeder_if (both handshakes)
//   All beat outputs are registered; o_ready is formed from registered state
//   and the downstream i_ready so that a new pair can be captured on the very
//   cycle the last beat of the previous pair is accepted.
// ---------------------------------------------------------------------------
module sip_bitplane_feeder
  import sip_bitplane_feeder_pkg::*;
(
  input  logic              i_CLK,
  input  logic              i_RST,
  sip_bitplane_feeder_if.master bus
);

  // FSM
  feeder_state_e state_q, state_d;

  // Goes high on the first clock after reset so o_ready stays low in reset.
  logic ready_en_q;

  // Captured vector pair and its controls
  logic [ACT_VEC_W-1:0] act_q, act_d;
  logic [WGT_VEC_W-1:0] wgt_q, wgt_d;
  logic [PREC_W-1:0]    act_prec_q, act_prec_d;
  logic [PREC_W-1:0]    wgt_prec_q, wgt_prec_d;
  logic                 act_sgn_q, act_sgn_d;
  logic                 wgt_sgn_q, wgt_sgn_d;
  logic                 bin_q, bin_d;

  // Plane indices of the beat on the outputs
  logic [PREC_W-1:0]    a_idx_q, a_idx_d;
  logic [PREC_W-1:0]    w_idx_q, w_idx_d;

  // Registered beat outputs
  logic                  valid_q, valid_d;
  logic [N_DOT-1:0]      act_plane_q, act_plane_d;
  logic [N_DOT-1:0]      wgt_plane_q, wgt_plane_d;
  logic                  sign_i_q, sign_i_d;
  logic                  sign_w_q, sign_w_d;
  logic                  bin_out_q, bin_out_d;
  logic [BITS_SHIFT-1:0] shift_q, shift_d;
  logic                  first_q, first_d;
  logic                  last_q, last_d;

  // Handshake qualifiers
  logic             ready;
  logic             capture;
  logic             beat_accept;
  logic [N_DOT-1:0] act_sel;
  logic [N_DOT-1:0] wgt_sel;

  assign ready       = ((state_q == IDLE) & ready_en_q) |
                       ((state_q == STREAM) & last_q & bus.i_ready);
  assign capture     = bus.i_valid & ready;
  assign beat_accept = valid_q & bus.i_ready;

  // Planes are selected from next-cycle data so the output registers load
  // the upcoming beat directly (this also covers the zero-gap capture case).
  sip_bitplane_feeder_bitplane_select #(
    .N_LANES   (N_DOT),
    .LANE_BITS (MAX_ACT_BITS)
  ) u_act_sel (
    .vec_i   (act_d),
    .idx_i   (a_idx_d),
    .plane_o (act_sel)
  );

  sip_bitplane_feeder_bitplane_select #(
    .N_LANES   (N_DOT),
    .LANE_BITS (MAX_WGT_BITS)
  ) u_wgt_sel (
    .vec_i   (wgt_d),
    .idx_i   (w_idx_d),
    .plane_o (wgt_sel)
  );

  // FSM next-state: a capture always (re)starts streaming, the last accepted
  // beat without a capture returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = STREAM;
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (capture) begin
          state_d = STREAM;
        end else if (beat_accept && last_q) begin
          state_d = IDLE;
        end else begin
          state_d = STREAM;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture registers and plane index counters (activation index inner).
  always_comb begin
    act_d      = act_q;
    wgt_d      = wgt_q;
    act_prec_d = act_prec_q;
    wgt_prec_d = wgt_prec_q;
    act_sgn_d  = act_sgn_q;
    wgt_sgn_d  = wgt_sgn_q;
    bin_d      = bin_q;
    a_idx_d    = a_idx_q;
    w_idx_d    = w_idx_q;
    if (capture) begin
      act_d      = bus.i_Act_vec;
      wgt_d      = bus.i_Wgt_vec;
      act_prec_d = bus.i_act_prec;
      wgt_prec_d = bus.i_wgt_prec;
      act_sgn_d  = bus.i_act_signed;
      wgt_sgn_d  = bus.i_wgt_signed;
      bin_d      = bus.i_bin;
      a_idx_d    = IDX_ZERO;
      w_idx_d    = IDX_ZERO;
    end else if (beat_accept && !last_q) begin
      // Not the last beat, so a wrap of a_idx always leaves room in w_idx.
      if (a_idx_q == act_prec_q) begin
        a_idx_d = IDX_ZERO;
        w_idx_d = w_idx_q + IDX_ONE;
      end else begin
        a_idx_d = a_idx_q + IDX_ONE;
        w_idx_d = w_idx_q;
      end
    end else begin
      a_idx_d = a_idx_q;
      w_idx_d = w_idx_q;
    end
  end

  // Next values of the beat outputs; everything is zero outside STREAM.
  always_comb begin
    valid_d     = 1'b0;
    act_plane_d = '0;
    wgt_plane_d = '0;
    sign_i_d    = 1'b0;
    sign_w_d    = 1'b0;
    bin_out_d   = 1'b0;
    shift_d     = 3'd0;
    first_d     = 1'b0;
    last_d      = 1'b0;
    if (state_d == STREAM) begin
      valid_d     = 1'b1;
      act_plane_d = act_sel;
      wgt_plane_d = wgt_sel;
      sign_i_d    = is_sign_plane(a_idx_d, act_prec_d, act_sgn_d, bin_d);
      sign_w_d    = is_sign_plane(w_idx_d, wgt_prec_d, wgt_sgn_d, bin_d);
      bin_out_d   = bin_d;
      shift_d     = beat_shift(a_idx_d, w_idx_d, bin_d);
      first_d     = (a_idx_d == IDX_ZERO) && (w_idx_d == IDX_ZERO);
      last_d      = bin_d | ((a_idx_d == act_prec_d) && (w_idx_d == wgt_prec_d));
    end else begin
      valid_d     = 1'b0;
    end
  end

  // State, capture and output registers.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q     <= IDLE;
      ready_en_q  <= 1'b0;
      act_q       <= '0;
      wgt_q       <= '0;
      act_prec_q  <= IDX_ZERO;
      wgt_prec_q  <= IDX_ZERO;
      act_sgn_q   <= 1'b0;
      wgt_sgn_q   <= 1'b0;
      bin_q       <= 1'b0;
      a_idx_q     <= IDX_ZERO;
      w_idx_q     <= IDX_ZERO;
      valid_q     <= 1'b0;
      act_plane_q <= '0;
      wgt_plane_q <= '0;
      sign_i_q    <= 1'b0;
      sign_w_q    <= 1'b0;
      bin_out_q   <= 1'b0;
      shift_q     <= 3'd0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_en_q  <= 1'b1;
      act_q       <= act_d;
      wgt_q       <= wgt_d;
      act_prec_q  <= act_prec_d;
      wgt_prec_q  <= wgt_prec_d;
      act_sgn_q   <= act_sgn_d;
      wgt_sgn_q   <= wgt_sgn_d;
      bin_q       <= bin_d;
      a_idx_q     <= a_idx_d;
      w_idx_q     <= w_idx_d;
      valid_q     <= valid_d;
      act_plane_q <= act_plane_d;
      wgt_plane_q <= wgt_plane_d;
      sign_i_q    <= sign_i_d;
      sign_w_q    <= sign_w_d;
      bin_out_q   <= bin_out_d;
      shift_q     <= shift_d;
      first_q     <= first_d;
      last_q      <= last_d;
    end
  end

  assign bus.o_ready  = ready;
  assign bus.o_valid  = valid_q;
  assign bus.o_Act    = act_plane_q;
  assign bus.o_Weight = wgt_plane_q;
  assign bus.o_SignI  = sign_i_q;
  assign bus.o_SignW  = sign_w_q;
  assign bus.o_bin    = bin_out_q;
  assign bus.o_shift  = shift_q;
  assign bus.o_first  = first_q;
  assign bus.o_last   = last_q;

endmodule

// File: tb/tb_sip_bitplane_feeder.sv
// ---------------------------------------------------------------------------
// tb_sip_bitplane_feeder
//   Directed bench for the bit-plane feeder. Lanes 0 and 1 carry the
//   hand-picked operand values; the other lanes carry filler. Beat fields
//   are compared against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_sip_bitplane_feeder;
  import sip_bitplane_feeder_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;
  int   acc_cnt = 0;
  int   base;

  sip_bitplane_feeder_if bus ();

  sip_bitplane_feeder dut (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted beats.
  always @(posedge clk) begin
    if (bus.o_valid && bus.i_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ACT_VEC_W-1:0] mk_vec(input logic [3:0] l0, input logic [3:0] l1);
    return {{30{4'h5}}, l1, l0};
  endfunction

  task automatic load(input logic [ACT_VEC_W-1:0] av, input logic [WGT_VEC_W-1:0] wv,
                      input logic [1:0] ap, input logic [1:0] wp,
                      input logic as_, input logic ws_, input logic bn);
    bus.i_Act_vec    = av;
    bus.i_Wgt_vec    = wv;
    bus.i_act_prec   = ap;
    bus.i_wgt_prec   = wp;
    bus.i_act_signed = as_;
    bus.i_wgt_signed = ws_;
    bus.i_bin        = bn;
    bus.i_valid      = 1'b1;
  endtask

  // act/wgt are {lane1, lane0} plane bits.
  task automatic chk_beat(input string tag, input logic [2:0] sh, input logic fi, input logic la,
                          input logic [1:0] act, input logic [1:0] wgt,
                          input logic si, input logic sw, input logic bn);
    chk_eq({tag, ".valid"}, 32'(bus.o_valid), 32'd1);
    chk_eq({tag, ".shift"}, 32'(bus.o_shift), 32'(sh));
    chk_eq({tag, ".first"}, 32'(bus.o_first), 32'(fi));
    chk_eq({tag, ".last"},  32'(bus.o_last),  32'(la));
    chk_eq({tag, ".act"},   32'(bus.o_Act[1:0]),    32'(act));
    chk_eq({tag, ".wgt"},   32'(bus.o_Weight[1:0]), 32'(wgt));
    chk_eq({tag, ".signi"}, 32'(bus.o_SignI), 32'(si));
    chk_eq({tag, ".signw"}, 32'(bus.o_SignW), 32'(sw));
    chk_eq({tag, ".bin"},   32'(bus.o_bin),   32'(bn));
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.i_ready = 1'b1;
    load('0, '0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    bus.i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst.valid", 32'(bus.o_valid), 32'd0);
    chk_eq("rst.ready", 32'(bus.o_ready), 32'd0);
    chk_eq("rst.first", 32'(bus.o_first), 32'd0);
    chk_eq("rst.last",  32'(bus.o_last),  32'd0);
    chk_eq("rst.shift", 32'(bus.o_shift), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk_eq("idle.ready", 32'(bus.o_ready), 32'd1);
    chk_eq("idle.valid", 32'(bus.o_valid), 32'd0);

    // 1: 2b x 2b unsigned, lane0 act=..10 wgt=..11, lane1 act=..01 wgt=..10
    base = acc_cnt;
    load(mk_vec(4'hE, 4'h1), mk_vec(4'h3, 4'h2), 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    step();
    bus.i_valid = 1'b0;
    chk_beat("t1.b0", 3'd0, 1'b1, 1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0);
    chk_eq("t1.b0.ready", 32'(bus.o_ready), 32'd0);
    step(); chk_beat("t1.b1", 3'd1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    step(); chk_beat("t1.b2", 3'd1, 1'b0, 1'b0, 2'b10, 2'b11, 1'b0, 1'b0, 1'b0);
    step(); chk_beat("t1.b3", 3'd2, 1'b0, 1'b1, 2'b01, 2'b11, 1'b0, 1'b0, 1'b0);
    chk_eq("t1.b3.ready", 32'(bus.o_ready), 32'd1);
    step();
    chk_eq("t1.end.valid", 32'(bus.o_valid), 32'd0);
    chk_eq("t1.end.ready", 32'(bus.o_ready), 32'd1);
    chk_eq("t1.beats", 32'(acc_cnt - base), 32'd4);

    // 2: binary mode, prec 3 and signed flags ignored
    base = acc_cnt;
    load(mk_vec(4'hF, 4'h2), mk_vec(4'h0, 4'h1), 2'd3, 2'd3, 1'b1, 1'b1, 1'b1);
    step();
    bus.i_valid = 1'b0;
    chk_beat("t2.b0", 3'd0, 1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 1'b0, 1'b1);
    step();
    chk_eq("t2.end.valid", 32'(bus.o_valid), 32'd0);
    chk_eq("t2.beats", 32'(acc_cnt - base), 32'd1);

    // 3: signed 4b act x 1b wgt, then with signed weights
    for (int v = 0; v < 2; v++) begin
      logic sw;
      sw = (v == 1);
      base = acc_cnt;
      load(mk_vec(4'h9, 4'h6), mk_vec(4'hE, 4'h1), 2'd3, 2'd0, 1'b1, sw, 1'b0);
      step();
      bus.i_valid = 1'b0;
      chk_beat($sformatf("t3.%0d.b0", v), 3'd0, 1'b1, 1'b0, 2'b01, 2'b10, 1'b0, sw, 1'b0);
      step(); chk_beat($sformatf("t3.%0d.b1", v), 3'd1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, sw, 1'b0);
      step(); chk_beat($sformatf("t3.%0d.b2", v), 3'd2, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, sw, 1'b0);
      step(); chk_beat($sformatf("t3.%0d.b3", v), 3'd3, 1'b0, 1'b1, 2'b01, 2'b10, 1'b1, sw, 1'b0);
      step();
      chk_eq($sformatf("t3.%0d.beats", v), 32'(acc_cnt - base), 32'd4);
    end

    // 4: backpressure for 3 cycles on beat 1
    base = acc_cnt;
    load(mk_vec(4'hE, 4'h1), mk_vec(4'h3, 4'h2), 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    step();
    bus.i_valid = 1'b0;
    chk_beat("t4.b0", 3'd0, 1'b1, 1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0);
    step();
    bus.i_ready = 1'b0;
    #1;
    chk_eq("t4.stall.ready", 32'(bus.o_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk_beat($sformatf("t4.hold%0d", c), 3'd1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    end
    bus.i_ready = 1'b1;
    #1;
    chk_beat("t4.b1", 3'd1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    step(); chk_beat("t4.b2", 3'd1, 1'b0, 1'b0, 2'b10, 2'b11, 1'b0, 1'b0, 1'b0);
    step(); chk_beat("t4.b3", 3'd2, 1'b0, 1'b1, 2'b01, 2'b11, 1'b0, 1'b0, 1'b0);
    step();
    chk_eq("t4.end.valid", 32'(bus.o_valid), 32'd0);
    chk_eq("t4.beats", 32'(acc_cnt - base), 32'd4);

    // 5: back-to-back 2x2 pairs with i_valid held
    base = acc_cnt;
    load(mk_vec(4'hE, 4'h1), mk_vec(4'h3, 4'h2), 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    step();
    load(mk_vec(4'h1, 4'h2), mk_vec(4'h2, 4'h1), 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    #1;
    chk_beat("t5.a0", 3'd0, 1'b1, 1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0);
    chk_eq("t5.a0.ready", 32'(bus.o_ready), 32'd0);
    step(); chk_beat("t5.a1", 3'd1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    chk_eq("t5.a1.ready", 32'(bus.o_ready), 32'd0);
    step(); chk_beat("t5.a2", 3'd1, 1'b0, 1'b0, 2'b10, 2'b11, 1'b0, 1'b0, 1'b0);
    chk_eq("t5.a2.ready", 32'(bus.o_ready), 32'd0);
    step(); chk_beat("t5.a3", 3'd2, 1'b0, 1'b1, 2'b01, 2'b11, 1'b0, 1'b0, 1'b0);
    chk_eq("t5.a3.ready", 32'(bus.o_ready), 32'd1);
    step();
    bus.i_valid = 1'b0;
    #1;
    chk_beat("t5.b0", 3'd0, 1'b1, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0);
    chk_eq("t5.b0.ready", 32'(bus.o_ready), 32'd0);
    step(); chk_beat("t5.b1", 3'd1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0);
    step(); chk_beat("t5.b2", 3'd1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    step(); chk_beat("t5.b3", 3'd2, 1'b0, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0);
    chk_eq("t5.b3.ready", 32'(bus.o_ready), 32'd1);
    step();
    chk_eq("t5.end.valid", 32'(bus.o_valid), 32'd0);
    chk_eq("t5.end.ready", 32'(bus.o_ready), 32'd1);
    chk_eq("t5.beats", 32'(acc_cnt - base), 32'd8);

    // 6: reset on beat 2, then a fresh capture restarts at beat 0
    load(mk_vec(4'hE, 4'h1), mk_vec(4'h3, 4'h2), 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    step();
    bus.i_valid = 1'b0;
    step();
    step();
    chk_beat("t6.b2", 3'd1, 1'b0, 1'b0, 2'b10, 2'b11, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk_eq("t6.rst.valid", 32'(bus.o_valid), 32'd0);
    chk_eq("t6.rst.ready", 32'(bus.o_ready), 32'd0);
    chk_eq("t6.rst.shift", 32'(bus.o_shift), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk_eq("t6.idle.ready", 32'(bus.o_ready), 32'd1);
    chk_eq("t6.idle.valid", 32'(bus.o_valid), 32'd0);
    load(mk_vec(4'hE, 4'h1), mk_vec(4'h3, 4'h2), 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    step();
    bus.i_valid = 1'b0;
    chk_beat("t6.n0", 3'd0, 1'b1, 1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0);
    step();
    step();
    step(); chk_beat("t6.n3", 3'd2, 1'b0, 1'b1, 2'b01, 2'b11, 1'b0, 1'b0, 1'b0);
    step();
    chk_eq("t6.end.valid", 32'(bus.o_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
